// File: rtl/lattice_loader.sv
// lattice_loader: host-side sequencer for the lattice address generator.
// Streams n+1 leaf values into node RAM, kicks the generator with a one-cycle
// start pulse, waits for its write burst to finish, then reads the root node
// (address 0) and hands it back to the host over valid/ready.
// Optional feature: define LOADER_WATCHDOG_EN to abort a run whose generator
// never finishes. The abort fires after WD_CYC cycles spent in the wait states.
module lattice_loader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WD_CYC = 65535
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [15:0]       cfg_n,
  input  logic              go,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ld_wraddr,
  output logic [DATA_W-1:0] ld_wrdata,
  output logic              ld_wren,
  output logic              ld_sel,
  output logic              start,
  input  logic              core_wren,
  output logic [ADDR_W-1:0] ld_rdaddr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              err
);

  // Read-latency counter must hold values 0..RD_LAT.
  localparam int unsigned RcW = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitRise,
    StWaitFall,
    StRead,
    StResult
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  // Set once word n has been accepted; the cycle it is high carries the last write.
  logic                done_q, done_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   wraddr_q, wraddr_d;
  logic [DATA_W-1:0]   wrdata_q, wrdata_d;
  logic [RcW-1:0]      rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_valid_q, res_valid_d;
  logic                err_c;
  logic                cfg_bad;
  logic                hs_in;

`ifdef LOADER_WATCHDOG_EN
  logic [15:0]         wd_q, wd_d;
`endif

  // n must be 1..2^ADDR_W-1 so the n+1 leaves fit the node RAM.
  assign cfg_bad = (cfg_n == 16'd0) || (cfg_n[15:ADDR_W] != '0);
  assign hs_in   = in_valid && in_ready;

  // Output decode from the current state; write port and result are registered.
  assign in_ready  = (state_q == StLoad) && !done_q;
  assign ld_sel    = !((state_q == StStart) || (state_q == StWaitRise) ||
                       (state_q == StWaitFall));
  assign start     = (state_q == StStart);
  assign busy      = (state_q != StIdle);
  assign ld_rdaddr = '0;
  assign ld_wren   = wren_q;
  assign ld_wraddr = wraddr_q;
  assign ld_wrdata = wrdata_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign err       = err_c;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    wren_d      = 1'b0;
    wraddr_d    = wraddr_q;
    wrdata_d    = wrdata_q;
    rd_cnt_d    = rd_cnt_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    err_c       = 1'b0;
`ifdef LOADER_WATCHDOG_EN
    wd_d        = wd_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (go) begin
          if (cfg_bad) begin
            err_c = 1'b1;
          end else begin
            n_d     = cfg_n[ADDR_W:0];
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = StLoad;
          end
        end
      end

      StLoad: begin
        if (hs_in) begin
          wren_d   = 1'b1;
          wraddr_d = cnt_q[ADDR_W-1:0];
          wrdata_d = in_data;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == n_q) begin
            done_d = 1'b1;
          end
        end
        // Leave only while the final write is on the port, so start follows it.
        if (done_q) begin
          state_d = StStart;
        end
      end

      StStart: begin
        state_d = StWaitRise;
`ifdef LOADER_WATCHDOG_EN
        wd_d    = '0;
`endif
      end

      StWaitRise: begin
`ifdef LOADER_WATCHDOG_EN
        if (core_wren) begin
          state_d = StWaitFall;
          wd_d    = '0;
        end else if (wd_q + 16'd1 == 16'(WD_CYC)) begin
          err_c   = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`else
        if (core_wren) begin
          state_d = StWaitFall;
        end
`endif
      end

      StWaitFall: begin
`ifdef LOADER_WATCHDOG_EN
        if (!core_wren) begin
          state_d  = StRead;
          rd_cnt_d = '0;
        end else if (wd_q + 16'd1 == 16'(WD_CYC)) begin
          err_c   = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`else
        if (!core_wren) begin
          state_d  = StRead;
          rd_cnt_d = '0;
        end
`endif
      end

      StRead: begin
        // Address 0 is driven from the first READ cycle; data lands RD_LAT later.
        if (rd_cnt_q == RcW'(RD_LAT)) begin
          res_data_d  = rd_data;
          res_valid_d = 1'b1;
          state_d     = StResult;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end

      StResult: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= StIdle;
      n_q         <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      wren_q      <= 1'b0;
      wraddr_q    <= '0;
      wrdata_q    <= '0;
      rd_cnt_q    <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      wren_q      <= wren_d;
      wraddr_q    <= wraddr_d;
      wrdata_q    <= wrdata_d;
      rd_cnt_q    <= rd_cnt_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef LOADER_WATCHDOG_EN
  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

endmodule

// File: tb/tb_lattice_loader.sv
// tb_lattice_loader: directed bench for lattice_loader with a small node-RAM
// read model and a write/start monitor.
module tb_lattice_loader;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned WD_CYC = 50;

  logic              clk = 1'b0;
  logic              nrst;
  logic [15:0]       cfg_n;
  logic              go;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] ld_wraddr;
  logic [DATA_W-1:0] ld_wrdata;
  logic              ld_wren;
  logic              ld_sel;
  logic              start;
  logic              core_wren;
  logic [ADDR_W-1:0] ld_rdaddr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic              err;

  int errors = 0;
  int checks = 0;

  lattice_loader #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT),
    .WD_CYC(WD_CYC)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .cfg_n    (cfg_n),
    .go       (go),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ld_wraddr(ld_wraddr),
    .ld_wrdata(ld_wrdata),
    .ld_wren  (ld_wren),
    .ld_sel   (ld_sel),
    .start    (start),
    .core_wren(core_wren),
    .ld_rdaddr(ld_rdaddr),
    .rd_data  (rd_data),
    .res_data (res_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Node RAM read model: root value appears RD_LAT cycles after the loader
  // drives address 0 with port ownership; anything else reads as garbage.
  logic [RD_LAT-1:0] rd_pipe = '0;
  always @(posedge clk) begin
    rd_pipe <= {rd_pipe[RD_LAT-2:0], (ld_sel && (ld_rdaddr == '0))};
  end
  assign rd_data = rd_pipe[RD_LAT-1] ? 32'h0000_1234 : 32'hDEAD_BEEF;

  // Monitor: log every RAM write and start pulse with its cycle number.
  int                cyc_n = 0;
  int                start_cnt = 0;
  int                start_cyc = -1;
  int                last_wr_cyc = -1;
  int                viol = 0;
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [DATA_W-1:0] wr_data_log[$];
  always @(posedge clk) begin
    if (ld_wren) begin
      wr_addr_log.push_back(ld_wraddr);
      wr_data_log.push_back(ld_wrdata);
      last_wr_cyc = cyc_n;
    end
    if (start) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc_n;
    end
    if (ld_wren && !ld_sel) viol = viol + 1;
    cyc_n = cyc_n + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Global time bound so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int n_before;
    int s_before;
    logic [DATA_W-1:0] held;
    logic stable;

    nrst      = 1'b0;
    cfg_n     = '0;
    go        = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    core_wren = 1'b0;
    res_ready = 1'b0;
    repeat (3) cyc();

    // Reset values.
    check("rst_ld_sel",    ld_sel,    1);
    check("rst_in_ready",  in_ready,  0);
    check("rst_ld_wren",   ld_wren,   0);
    check("rst_start",     start,     0);
    check("rst_busy",      busy,      0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data",  res_data,  0);
    check("rst_err",       err,       0);
    nrst = 1'b1;
    cyc();

    // Run 1: n=4, leaves 10..14 back-to-back.
    cfg_n = 16'd4;
    go    = 1'b1;
    cyc();
    go = 1'b0;
    check("r1_busy",     busy,     1);
    check("r1_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(10 + i);
      cyc();
    end
    in_valid = 1'b0;
    k = 0;
    while (!start && k < 10) begin
      cyc();
      k++;
    end
    check("r1_start_seen", start, 1);
    check("r1_sel_in_start", ld_sel, 0);
    // go is ignored while busy.
    cfg_n = 16'd7;
    go    = 1'b1;
    #1;
    check("r1_go_busy_err", err, 0);
    cyc();
    go = 1'b0;
    check("r1_start_single", start, 0);
    check("r1_wait_in_ready", in_ready, 0);
    // Generator model: wren rises 30 cycles after start, high for 100 cycles.
    repeat (29) cyc();
    core_wren = 1'b1;
    repeat (100) cyc();
    core_wren = 1'b0;
    k = 0;
    while (!res_valid && k < 20) begin
      cyc();
      k++;
    end
    // First edge sampling the fall is edge 1; result is RD_LAT+1 edges later.
    check("r1_res_latency", k, RD_LAT + 2);
    check("r1_res_data", res_data, 32'h0000_1234);
    check("r1_sel_result", ld_sel, 1);
    held   = res_data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!res_valid || res_data !== held) stable = 1'b0;
    end
    check("r1_res_stable", stable, 1);
    res_ready = 1'b1;
    go        = 1'b1;
    cfg_n     = 16'd4;
    cyc();
    res_ready = 1'b0;
    go        = 1'b0;
    check("r1_res_cleared", res_valid, 0);
    check("r1_idle_busy",   busy,      0);
    check("r1_idle_sel",    ld_sel,    1);
    check("r1_wr_count", wr_addr_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_addr_log.size()) begin
        check($sformatf("r1_wr_addr%0d", i), wr_addr_log[i], i);
        check($sformatf("r1_wr_data%0d", i), wr_data_log[i], 10 + i);
      end
    end
    check("r1_start_cnt", start_cnt, 1);
    check("r1_start_after_wr", start_cyc, last_wr_cyc + 1);

    // Run 2: n=4 with in_valid toggling; extra offers after the fifth are refused.
    wr_addr_log.delete();
    wr_data_log.delete();
    cfg_n = 16'd4;
    go    = 1'b1;
    cyc();
    go = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 32'(20 + i);
      cyc();
    end
    in_valid = 1'b0;
    check("r2_wr_count", wr_addr_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_addr_log.size()) begin
        check($sformatf("r2_wr_addr%0d", i), wr_addr_log[i], i);
        check($sformatf("r2_wr_data%0d", i), wr_data_log[i], 20 + 2 * i);
      end
    end
    check("r2_start_cnt", start_cnt, 2);
    core_wren = 1'b1;
    repeat (5) cyc();
    core_wren = 1'b0;
    k = 0;
    while (!res_valid && k < 20) begin
      cyc();
      k++;
    end
    check("r2_res_valid", res_valid, 1);
    check("r2_res_data", res_data, 32'h0000_1234);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    check("r2_idle_busy", busy, 0);

    // Bad configurations: cfg_n = 0 and cfg_n = 4096.
    n_before = wr_addr_log.size();
    cfg_n = 16'd0;
    go    = 1'b1;
    #1;
    check("bad0_err", err, 1);
    cyc();
    go = 1'b0;
    #1;
    check("bad0_err_done", err, 0);
    check("bad0_busy", busy, 0);
    cfg_n = 16'd4096;
    go    = 1'b1;
    #1;
    check("bad4096_err", err, 1);
    cyc();
    go = 1'b0;
    #1;
    check("bad4096_err_done", err, 0);
    check("bad4096_busy", busy, 0);
    cyc();
    check("bad_no_writes", wr_addr_log.size(), n_before);

    // Reset pulsed during LOAD.
    s_before = start_cnt;
    cfg_n = 16'd4;
    go    = 1'b1;
    cyc();
    go       = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'd5;
    cyc();
    cyc();
    check("rl_wren_mid", ld_wren, 1);
    nrst = 1'b0;
    cyc();
    check("rl_wren",      ld_wren,   0);
    check("rl_in_ready",  in_ready,  0);
    check("rl_sel",       ld_sel,    1);
    check("rl_busy",      busy,      0);
    check("rl_start",     start,     0);
    check("rl_res_valid", res_valid, 0);
    check("rl_err",       err,       0);
    nrst     = 1'b1;
    in_valid = 1'b0;
    repeat (10) cyc();
    check("rl_no_start", start_cnt, s_before);
    check("rl_still_idle", busy, 0);

`ifdef LOADER_WATCHDOG_EN
    // Watchdog: generator never writes; abort WD_CYC cycles after the start pulse.
    cfg_n = 16'd1;
    go    = 1'b1;
    cyc();
    go       = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'd7;
    cyc();
    cyc();
    in_valid = 1'b0;
    k = 0;
    while (!start && k < 10) begin
      cyc();
      k++;
    end
    check("wd_start_seen", start, 1);
    k = 0;
    while (!err && k < 100) begin
      cyc();
      k++;
    end
    check("wd_err_delay", k, WD_CYC);
    cyc();
    check("wd_idle_busy", busy, 0);
    check("wd_idle_sel", ld_sel, 1);
    check("wd_no_result", res_valid, 0);
    check("wd_err_single", err, 0);
`endif

    check("wren_sel_exclusive", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
